// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider among N_REQ requesters.
// Optional WAIT-state timeout is enabled with `define DIV_TIMEOUT_EN.
module div_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 26,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] dividend_in,
  input  logic [N_REQ*DW-1:0] divisor_in,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    res_valid,
  output logic [DW-1:0]       quotient,
  output logic [DW-1:0]       remainder,
  output logic                err,
  output logic                busy,
  output logic                div_data_rdy,
  output logic [DW-1:0]       div_dividend,
  output logic [DW-1:0]       div_divisor,
  input  logic                div_res_rdy,
  input  logic [DW-1:0]       div_merchant,
  input  logic [DW-1:0]       div_remainder
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Round-robin pick: first requester at or above ptr, wrapping.
  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  int unsigned   cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          dvd_d   = dividend_in[32'(pick_idx)*DW +: DW];
          dvs_d   = divisor_in[32'(pick_idx)*DW +: DW];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dvs_q != '0) begin
`ifdef DIV_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = S_WAIT;
        end else begin
          // Divide by zero never reaches the divider.
          quo_d   = '1;
          rem_d   = dvd_q;
`ifdef DIV_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (div_res_rdy) begin
          quo_d   = div_merchant;
          rem_d   = div_remainder;
`ifdef DIV_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef DIV_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          quo_d   = '1;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        ptr_d   = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack          = '0;
    res_valid    = '0;
    div_data_rdy = 1'b0;
    err          = 1'b0;
    busy         = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        ack[gnt_q]   = 1'b1;
        div_data_rdy = (dvs_q != '0);
      end
      S_RESP: begin
        res_valid[gnt_q] = 1'b1;
`ifdef DIV_TIMEOUT_EN
        err              = err_q;
`endif
      end
      default: ;
    endcase
  end

  assign quotient     = quo_q;
  assign remainder    = rem_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule
